// File: rtl/fill_rect_cmd_encoder.sv
// Serialises a fill-rect command into the command-FIFO byte stream.
// Define FILL_RECT_ENC_OPCODE_EN to prefix each command with OPCODE.
module fill_rect_cmd_encoder #(
    parameter logic [7:0] OPCODE = 8'h02
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        cmd_in_rts,
    output logic        cmd_in_rtr,
    input  logic [15:0] cmd_in_origx,
    input  logic [15:0] cmd_in_origy,
    input  logic [15:0] cmd_in_wid,
    input  logic [15:0] cmd_in_hgt,
    input  logic [3:0]  cmd_in_rval,
    input  logic [3:0]  cmd_in_gval,
    input  logic [3:0]  cmd_in_bval,
    output logic        cmd_fifo_rts,
    input  logic        cmd_fifo_rtr,
    output logic [7:0]  cmd_fifo_data,
    output logic        enc_busy,
    output logic        enc_done_strobe
);

    typedef enum logic [3:0] {
        IDLE,
`ifdef FILL_RECT_ENC_OPCODE_EN
        OPC,
`endif
        ORIGX_B1, ORIGX_B2,
        ORIGY_B1, ORIGY_B2,
        WID_B1, WID_B2,
        HGT_B1, HGT_B2,
        R, G, B
    } state_t;

`ifdef FILL_RECT_ENC_OPCODE_EN
    localparam state_t FIRST = OPC;
`else
    localparam state_t FIRST = ORIGX_B1;
`endif

    state_t      state_q, state_d;
    logic [15:0] origx_q, origy_q, wid_q, hgt_q;
    logic [3:0]  rval_q, gval_q, bval_q;

    logic        idle, load, in_xfer, out_xfer;
    logic [15:0] src_origx, src_origy, src_wid, src_hgt;
    logic [3:0]  src_r, src_g, src_b;
    logic [7:0]  byte_d, data_d;
    logic        rtr_d, rts_d, done_d;

    assign idle     = (state_q == IDLE);
    assign in_xfer  = cmd_in_rts & cmd_in_rtr;
    assign out_xfer = cmd_fifo_rts & cmd_fifo_rtr;
    assign load     = in_xfer & idle;
    assign enc_busy = ~idle;

    // The first byte is loaded in the accept cycle, before the fields are latched.
    assign src_origx = idle ? cmd_in_origx : origx_q;
    assign src_origy = idle ? cmd_in_origy : origy_q;
    assign src_wid   = idle ? cmd_in_wid   : wid_q;
    assign src_hgt   = idle ? cmd_in_hgt   : hgt_q;
    assign src_r     = idle ? cmd_in_rval  : rval_q;
    assign src_g     = idle ? cmd_in_gval  : gval_q;
    assign src_b     = idle ? cmd_in_bval  : bval_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (load)     state_d = FIRST;
`ifdef FILL_RECT_ENC_OPCODE_EN
            OPC:      if (out_xfer) state_d = ORIGX_B1;
`endif
            ORIGX_B1: if (out_xfer) state_d = ORIGX_B2;
            ORIGX_B2: if (out_xfer) state_d = ORIGY_B1;
            ORIGY_B1: if (out_xfer) state_d = ORIGY_B2;
            ORIGY_B2: if (out_xfer) state_d = WID_B1;
            WID_B1:   if (out_xfer) state_d = WID_B2;
            WID_B2:   if (out_xfer) state_d = HGT_B1;
            HGT_B1:   if (out_xfer) state_d = HGT_B2;
            HGT_B2:   if (out_xfer) state_d = R;
            R:        if (out_xfer) state_d = G;
            G:        if (out_xfer) state_d = B;
            B:        if (out_xfer) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_d = OPCODE;
        case (state_d)
            ORIGX_B1: byte_d = src_origx[15:8];
            ORIGX_B2: byte_d = src_origx[7:0];
            ORIGY_B1: byte_d = src_origy[15:8];
            ORIGY_B2: byte_d = src_origy[7:0];
            WID_B1:   byte_d = src_wid[15:8];
            WID_B2:   byte_d = src_wid[7:0];
            HGT_B1:   byte_d = src_hgt[15:8];
            HGT_B2:   byte_d = src_hgt[7:0];
            R:        byte_d = {4'h0, src_r};
            G:        byte_d = {4'h0, src_g};
            B:        byte_d = {4'h0, src_b};
            default:  byte_d = OPCODE;
        endcase
    end

    always_comb begin
        rtr_d  = cmd_in_rtr;
        rts_d  = cmd_fifo_rts;
        data_d = cmd_fifo_data;
        done_d = 1'b0;
        if (load) begin
            rtr_d = 1'b0;
            rts_d = 1'b1;
        end
        if (out_xfer && state_q == B) begin
            rtr_d  = 1'b1;
            rts_d  = 1'b0;
            done_d = 1'b1;
        end
        // Data only moves on a state step, so it holds across stalls.
        if (state_d != state_q && state_d != IDLE)
            data_d = byte_d;
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q         <= IDLE;
            cmd_in_rtr      <= 1'b1;
            cmd_fifo_rts    <= 1'b0;
            cmd_fifo_data   <= 8'h00;
            enc_done_strobe <= 1'b0;
            origx_q         <= '0;
            origy_q         <= '0;
            wid_q           <= '0;
            hgt_q           <= '0;
            rval_q          <= '0;
            gval_q          <= '0;
            bval_q          <= '0;
        end else begin
            state_q         <= state_d;
            cmd_in_rtr      <= rtr_d;
            cmd_fifo_rts    <= rts_d;
            cmd_fifo_data   <= data_d;
            enc_done_strobe <= done_d;
            if (load) begin
                origx_q <= cmd_in_origx;
                origy_q <= cmd_in_origy;
                wid_q   <= cmd_in_wid;
                hgt_q   <= cmd_in_hgt;
                rval_q  <= cmd_in_rval;
                gval_q  <= cmd_in_gval;
                bval_q  <= cmd_in_bval;
            end
        end
    end

endmodule

// File: tb/tb_fill_rect_cmd_encoder.sv
// Bench for fill_rect_cmd_encoder: vector table, corner sequences, random traffic.
// Honours FILL_RECT_ENC_OPCODE_EN when defined.
module tb_fill_rect_cmd_encoder;

`ifdef FILL_RECT_ENC_OPCODE_EN
    localparam int NB  = 12;
    localparam int OFS = 1;
`else
    localparam int NB  = 11;
    localparam int OFS = 0;
`endif
    localparam logic [7:0] OPC = 8'h02;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic        cmd_in_rts = 1'b0;
    logic        cmd_in_rtr;
    logic [15:0] cmd_in_origx = '0, cmd_in_origy = '0;
    logic [15:0] cmd_in_wid = '0, cmd_in_hgt = '0;
    logic [3:0]  cmd_in_rval = '0, cmd_in_gval = '0, cmd_in_bval = '0;
    logic        cmd_fifo_rts;
    logic        cmd_fifo_rtr = 1'b0;
    logic [7:0]  cmd_fifo_data;
    logic        enc_busy;
    logic        enc_done_strobe;

    fill_rect_cmd_encoder #(.OPCODE(OPC)) dut (
        .clk(clk), .rst_(rst_),
        .cmd_in_rts(cmd_in_rts), .cmd_in_rtr(cmd_in_rtr),
        .cmd_in_origx(cmd_in_origx), .cmd_in_origy(cmd_in_origy),
        .cmd_in_wid(cmd_in_wid), .cmd_in_hgt(cmd_in_hgt),
        .cmd_in_rval(cmd_in_rval), .cmd_in_gval(cmd_in_gval),
        .cmd_in_bval(cmd_in_bval),
        .cmd_fifo_rts(cmd_fifo_rts), .cmd_fifo_rtr(cmd_fifo_rtr),
        .cmd_fifo_data(cmd_fifo_data),
        .enc_busy(enc_busy), .enc_done_strobe(enc_done_strobe)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Reference model: queue of expected bytes plus bytes still owed.
    logic [7:0] exp_q[$];
    int         pending = 0;
    bit         done_exp = 0;
    bit         hold_v = 0;
    logic [7:0] hold_d = 8'h00;

    logic [7:0] got_b[$];
    int         got_c[$];
    int         acc_c[$];
    int         done_c[$];

    typedef struct {
        logic [15:0] x, y, w, h;
        logic [3:0]  r, g, b;
        logic [87:0] exp;
    } vec_t;
    vec_t tbl[3];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] req);
        tests++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)",
                     nm, got, req, cyc);
        end
    endtask

    task automatic push16(input logic [15:0] v);
        exp_q.push_back(8'(v / 16'd256));
        exp_q.push_back(8'(v % 16'd256));
    endtask

    task automatic push_cmd();
`ifdef FILL_RECT_ENC_OPCODE_EN
        exp_q.push_back(OPC);
`endif
        push16(cmd_in_origx);
        push16(cmd_in_origy);
        push16(cmd_in_wid);
        push16(cmd_in_hgt);
        exp_q.push_back({4'h0, cmd_in_rval});
        exp_q.push_back({4'h0, cmd_in_gval});
        exp_q.push_back({4'h0, cmd_in_bval});
    endtask

    function automatic logic [7:0] ref_byte(input logic [87:0] e,
                                            input int k);
        int j;
        j = k - OFS;
        if (j < 0) return OPC;
        return e[87 - 8*j -: 8];
    endfunction

    // Inputs change at posedge+1, so the negedge sees settled values.
    always @(negedge clk) begin : monitor
        bit dn;
        dn = 1'b0;
        if (rst_) begin
            chk("rst_rtr", cmd_in_rtr, 1);
            chk("rst_rts", cmd_fifo_rts, 0);
            chk("rst_data", cmd_fifo_data, 0);
            chk("rst_done", enc_done_strobe, 0);
            chk("rst_busy", enc_busy, 0);
            exp_q.delete();
            pending  = 0;
            done_exp = 1'b0;
            hold_v   = 1'b0;
        end else begin
            chk("busy", enc_busy, pending != 0);
            chk("in_rtr", cmd_in_rtr, pending == 0);
            chk("fifo_rts", cmd_fifo_rts, pending != 0);
            chk("done", enc_done_strobe, done_exp);
            if (hold_v) chk("stall_hold", cmd_fifo_data, hold_d);
            if (enc_done_strobe) done_c.push_back(cyc);
            if (cmd_fifo_rts && cmd_fifo_rtr) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL extra_byte: got %02h, required none",
                             cmd_fifo_data);
                end else begin
                    chk("byte", cmd_fifo_data, exp_q.pop_front());
                end
                got_b.push_back(cmd_fifo_data);
                got_c.push_back(cyc);
                if (pending > 0) pending--;
                if (pending == 0) dn = 1'b1;
            end
            hold_v = cmd_fifo_rts && !cmd_fifo_rtr;
            hold_d = cmd_fifo_data;
            if (cmd_in_rts && cmd_in_rtr) begin
                push_cmd();
                pending = NB;
                acc_c.push_back(cyc);
            end
            done_exp = dn;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        got_b.delete();
        got_c.delete();
        acc_c.delete();
        done_c.delete();
    endtask

    task automatic wait_acc(input int n);
        int k = 0;
        while (acc_c.size() <= n && k < 60) begin
            tick();
            k++;
        end
        chk("accept_timeout", acc_c.size() > n, 1);
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (done_c.size() <= n && k < 120) begin
            tick();
            k++;
        end
        chk("done_timeout", done_c.size() > n, 1);
    endtask

    task automatic drive_fields(input int i);
        cmd_in_origx = tbl[i].x;
        cmd_in_origy = tbl[i].y;
        cmd_in_wid   = tbl[i].w;
        cmd_in_hgt   = tbl[i].h;
        cmd_in_rval  = tbl[i].r;
        cmd_in_gval  = tbl[i].g;
        cmd_in_bval  = tbl[i].b;
    endtask

    task automatic check_bytes(input string nm, input int i, input int base);
        for (int k = 0; k < NB && base + k < got_b.size(); k++)
            chk(nm, got_b[base + k], ref_byte(tbl[i].exp, k));
    endtask

    task automatic run_vec(input int i);
        clear_logs();
        cmd_fifo_rtr = 1'b1;
        drive_fields(i);
        cmd_in_rts = 1'b1;
        wait_acc(0);
        cmd_in_rts = 1'b0;
        wait_done(0);
        tick();
        chk("vec_count", got_b.size(), NB);
        check_bytes("vec_byte", i, 0);
        if (got_c.size() == NB && acc_c.size() > 0) begin
            chk("vec_first_cyc", got_c[0] - acc_c[0], 1);
            chk("vec_last_cyc", got_c[NB-1] - acc_c[0], NB);
        end
        if (done_c.size() > 0 && acc_c.size() > 0)
            chk("vec_done_cyc", done_c[0] - acc_c[0], NB + 1);
        chk("vec_done_count", done_c.size(), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int stall_n;
        tbl[0] = '{16'h0123, 16'h0045, 16'h0010, 16'h0020, 4'hF, 4'h8, 4'h1,
                   88'h0123_0045_0010_0020_0F_08_01};
        tbl[1] = '{16'hFFFF, 16'h0000, 16'h8001, 16'h7FFE, 4'h0, 4'hF, 4'hA,
                   88'hFFFF_0000_8001_7FFE_00_0F_0A};
        tbl[2] = '{16'h00FF, 16'hFF00, 16'h1234, 16'hABCD, 4'h5, 4'hA, 4'hC,
                   88'h00FF_FF00_1234_ABCD_05_0A_0C};

        repeat (3) tick();
        rst_ = 1'b0;
        // rtr toggling while idle must not disturb anything
        repeat (4) begin
            cmd_fifo_rtr = ~cmd_fifo_rtr;
            tick();
        end

        for (int i = 0; i < 3; i++) run_vec(i);

        // backpressure: alternating rtr plus a 5-cycle stall at WID_B1
        clear_logs();
        drive_fields(0);
        cmd_fifo_rtr = 1'b0;
        cmd_in_rts = 1'b1;
        wait_acc(0);
        cmd_in_rts = 1'b0;
        k = 0;
        stall_n = 0;
        while (done_c.size() == 0 && k < 100) begin
            if (got_b.size() == OFS + 4 && stall_n < 5) begin
                cmd_fifo_rtr = 1'b0;
                stall_n++;
                chk("stall_wid_b1", cmd_fifo_data, 8'h00);
            end else begin
                cmd_fifo_rtr = (k % 2) == 0;
            end
            tick();
            k++;
        end
        chk("bp_done_seen", done_c.size(), 1);
        chk("bp_stall_len", stall_n, 5);
        chk("bp_count", got_b.size(), NB);
        check_bytes("bp_byte", 0, 0);
        cmd_fifo_rtr = 1'b1;
        tick();

        // input stability and back-to-back with rts held high
        clear_logs();
        drive_fields(0);
        cmd_in_rts = 1'b1;
        wait_acc(0);
        tick();
        cmd_in_origx = 16'hFFFF;
        wait_acc(1);
        cmd_in_rts = 1'b0;
        wait_done(1);
        tick();
        if (acc_c.size() > 1 && got_c.size() > NB) begin
            chk("b2b_accept_cyc", acc_c[1] - acc_c[0], NB + 1);
            chk("b2b_first_cyc", got_c[NB] - acc_c[0], NB + 2);
            chk("b2b_origx_new", got_b[NB + OFS], 8'hFF);
        end
        chk("b2b_done_count", done_c.size(), 2);
        chk("b2b_count", got_b.size(), 2 * NB);
        check_bytes("stable_byte", 0, 0);

        // reset after the 5th transfer
        clear_logs();
        drive_fields(0);
        cmd_in_rts = 1'b1;
        wait_acc(0);
        cmd_in_rts = 1'b0;
        k = 0;
        while (got_b.size() < 5 && k < 40) begin
            tick();
            k++;
        end
        chk("rst_mid_reached", got_b.size(), 5);
        rst_ = 1'b1;
        #1;
        chk("rst_mid_rts", cmd_fifo_rts, 0);
        chk("rst_mid_data", cmd_fifo_data, 0);
        chk("rst_mid_rtr", cmd_in_rtr, 1);
        chk("rst_mid_busy", enc_busy, 0);
        tick();
        tick();
        rst_ = 1'b0;
        tick();
        run_vec(0);

        // random traffic against the model
        clear_logs();
        for (int n = 0; n < 800; n++) begin
            cmd_in_rts   = ($urandom % 3) == 0;
            cmd_in_origx = 16'($urandom);
            cmd_in_origy = 16'($urandom);
            cmd_in_wid   = 16'($urandom);
            cmd_in_hgt   = 16'($urandom);
            cmd_in_rval  = 4'($urandom);
            cmd_in_gval  = 4'($urandom);
            cmd_in_bval  = 4'($urandom);
            cmd_fifo_rtr = ($urandom % 4) != 0;
            tick();
        end
        cmd_in_rts = 1'b0;
        cmd_fifo_rtr = 1'b1;
        k = 0;
        while (pending != 0 && k < 40) begin
            tick();
            k++;
        end
        tick();
        tick();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_done_per_cmd", done_c.size(), acc_c.size());
        chk("rand_byte_total", got_b.size(), acc_c.size() * NB);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
